// File: rtl/bemicro_cv_irq_ctrl.sv
// Interrupt aggregator: per-line level/edge latching, masking and a priority-encoded CPU request.
// Optional input synchroniser enabled by defining BEMICRO_CV_IRQ_CTRL_SYNC_EN.
module bemicro_cv_irq_ctrl #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [15:0]          writedata,
    output logic [15:0]          readdata,
    input  logic [NUM_IRQ-1:0]   irq_in,
    output logic                 irq_out,
    output logic [3:0]           irq_id
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ID_W   = 4;
    // Bits at or above NUM_IRQ are tied off so they read 0 and ignore writes.
    localparam logic [DATA_W-1:0] IMPL_MASK = DATA_W'((17'(1) << NUM_IRQ) - 17'(1));

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_PENDING  = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd4;
    localparam logic [2:0] ADDR_ID       = 3'd5;

    logic [DATA_W-1:0] s_c;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] pending;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] edge_sel;
    logic [DATA_W-1:0] clr_c;
    logic [DATA_W-1:0] pending_nxt_c;
    logic [DATA_W-1:0] active_c;
    logic [DATA_W-1:0] rd_c;
    logic [ID_W-1:0]   id_c;
    logic              wr_c;

`ifdef BEMICRO_CV_IRQ_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync_meta;
    logic [NUM_IRQ-1:0] sync_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= irq_in;
            sync_out  <= sync_meta;
        end
    end

    assign s_c = DATA_W'(sync_out);
`else
    assign s_c = DATA_W'(irq_in);
`endif

    assign wr_c     = chipselect && !write_n;
    assign active_c = pending & mask;

    // Per-line latch: level lines track s; edge lines set on a rise, W1C, set wins.
    always_comb begin
        clr_c         = '0;
        pending_nxt_c = pending;
        if (wr_c && (address == ADDR_PENDING))
            clr_c = writedata & IMPL_MASK;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (edge_sel[i])
                pending_nxt_c[i] = (s_c[i] & ~prev[i]) | (pending[i] & ~clr_c[i]);
            else
                pending_nxt_c[i] = s_c[i];
        end
    end

    // Lowest index wins; scan downward so the last hit is the smallest.
    always_comb begin
        id_c = '0;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            if (active_c[i])
                id_c = ID_W'(i);
        end
    end

    always_comb begin
        rd_c = '0;
        case (address)
            ADDR_STATUS:   rd_c = s_c;
            ADDR_PENDING:  rd_c = pending;
            ADDR_MASK:     rd_c = mask;
            ADDR_EDGE_SEL: rd_c = edge_sel;
            ADDR_ACTIVE:   rd_c = active_c;
            ADDR_ID:       rd_c = {irq_out, 11'd0, irq_id};
            default:       rd_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            pending  <= '0;
            mask     <= '0;
            edge_sel <= '0;
            irq_out  <= 1'b0;
            irq_id   <= '0;
            readdata <= '0;
        end else begin
            prev     <= s_c;
            pending  <= pending_nxt_c & IMPL_MASK;
            irq_out  <= |active_c;
            irq_id   <= id_c;
            readdata <= rd_c;
            if (wr_c && (address == ADDR_MASK))
                mask <= writedata & IMPL_MASK;
            if (wr_c && (address == ADDR_EDGE_SEL))
                edge_sel <= writedata & IMPL_MASK;
        end
    end

endmodule

// File: tb/tb_bemicro_cv_irq_ctrl.sv
// Directed self-checking bench for bemicro_cv_irq_ctrl (latencies follow BEMICRO_CV_IRQ_CTRL_SYNC_EN).
module tb_bemicro_cv_irq_ctrl;
`ifdef BEMICRO_CV_IRQ_CTRL_SYNC_EN
    localparam int LAT_OUT  = 3;
    localparam int LAT_PEND = 2;
`else
    localparam int LAT_OUT  = 1;
    localparam int LAT_PEND = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq_out;
    logic [3:0]  irq_id;

    int checks = 0;
    int errors = 0;

    bemicro_cv_irq_ctrl #(.NUM_IRQ(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq_out    (irq_out),
        .irq_id     (irq_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [15:0] d;
        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; irq_in = '0;
        tick(3);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out: got %b expected 0", irq_out); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL reset_irq_id: got %h expected 0", irq_id); end
        checks++; if (readdata !== 16'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0000", readdata); end
        reset_n = 1'b1;
        tick(1);
        rd(3'd2, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_mask: got %h expected 0000", d); end
        rd(3'd1, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0000", d); end
    endtask

    task automatic test_level;
        logic [15:0] d;
        wr(3'd2, 16'h0001);
        irq_in = 8'h01;
        for (int j = 0; j <= LAT_OUT; j++) begin
            @(posedge clk); #1;
            checks++;
            if (irq_out !== (j >= LAT_OUT)) begin
                errors++; $display("FAIL level_rise_t%0d: got %b expected %b", j, irq_out, (j >= LAT_OUT));
            end
        end
        rd(3'd5, d);
        checks++; if (d !== 16'h8000) begin errors++; $display("FAIL level_id_reg: got %h expected 8000", d); end
        rd(3'd0, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL level_status: got %h expected 0001", d); end
        wr(3'd1, 16'h0001);
        rd(3'd1, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL level_w1c_no_effect: got %h expected 0001", d); end
        tick(2);
        irq_in = 8'h00;
        for (int j = 0; j <= LAT_OUT; j++) begin
            @(posedge clk); #1;
            checks++;
            if (irq_out !== (j < LAT_OUT)) begin
                errors++; $display("FAIL level_fall_t%0d: got %b expected %b", j, irq_out, (j < LAT_OUT));
            end
        end
    endtask

    task automatic test_edge;
        logic [15:0] d;
        wr(3'd3, 16'h0004);
        wr(3'd2, 16'h0004);
        irq_in = 8'h04;
        tick(1);
        irq_in = 8'h00;
        tick(LAT_OUT + 1);
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL edge_irq_out: got %b expected 1", irq_out); end
        rd(3'd1, d);
        checks++; if (d !== 16'h0004) begin errors++; $display("FAIL edge_pending: got %h expected 0004", d); end
        tick(3);
        rd(3'd1, d);
        checks++; if (d !== 16'h0004) begin errors++; $display("FAIL edge_pending_held: got %h expected 0004", d); end
        wr(3'd1, 16'h0004);
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL edge_clr_same_cycle: got %b expected 1", irq_out); end
        tick(1);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL edge_clr_drop: got %b expected 0", irq_out); end
        rd(3'd1, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL edge_pending_cleared: got %h expected 0000", d); end
    endtask

    task automatic test_priority;
        wr(3'd3, 16'h0000);
        irq_in = 8'h28;
        wr(3'd2, 16'h00FF);
        tick(LAT_OUT + 1);
        checks++; if (irq_id !== 4'd3) begin errors++; $display("FAIL prio_id3: got %0d expected 3", irq_id); end
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL prio_irq_out: got %b expected 1", irq_out); end
        wr(3'd2, 16'h00F7);
        checks++; if (irq_id !== 4'd3) begin errors++; $display("FAIL prio_id_before: got %0d expected 3", irq_id); end
        tick(1);
        checks++; if (irq_id !== 4'd5) begin errors++; $display("FAIL prio_id5: got %0d expected 5", irq_id); end
        irq_in = 8'h00;
        tick(LAT_OUT + 1);
    endtask

    task automatic test_set_clear;
        logic [15:0] d;
        wr(3'd3, 16'h0002);
        wr(3'd2, 16'h0002);
        irq_in = 8'h02;
        tick(1);
        irq_in = 8'h00;
        tick(LAT_OUT + 1);
        rd(3'd1, d);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL sc_first_set: got %h expected 0002", d); end
        irq_in = 8'h02;
        tick(LAT_PEND);
        wr(3'd1, 16'h0002);
        rd(3'd1, d);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL sc_set_wins: got %h expected 0002", d); end
        wr(3'd1, 16'h0002);
        rd(3'd1, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL sc_clear_no_edge: got %h expected 0000", d); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL sc_irq_out: got %b expected 0", irq_out); end
        irq_in = 8'h00;
        tick(LAT_OUT + 1);
    endtask

    task automatic test_masking;
        logic [15:0] d;
        wr(3'd3, 16'h0000);
        wr(3'd2, 16'h0000);
        irq_in = 8'hFF;
        tick(LAT_OUT + 1);
        rd(3'd0, d);
        checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL mask_status: got %h expected 00ff", d); end
        rd(3'd4, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mask_active: got %h expected 0000", d); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mask_irq_out: got %b expected 0", irq_out); end
        rd(3'd6, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mask_addr6: got %h expected 0000", d); end
        rd(3'd7, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mask_addr7: got %h expected 0000", d); end
        wr(3'd2, 16'hFF00);
        rd(3'd2, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mask_upper_ignored: got %h expected 0000", d); end
        wr(3'd0, 16'h0000);
        rd(3'd0, d);
        checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL status_ro: got %h expected 00ff", d); end
        rd(3'd1, d);
        checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL mask_pending: got %h expected 00ff", d); end
        wr(3'd2, 16'hFFFF);
        rd(3'd2, d);
        checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL mask_all: got %h expected 00ff", d); end
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL mask_all_irq_out: got %b expected 1", irq_out); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        rd(3'd5, d);
        checks++; if (d !== 16'h8000) begin errors++; $display("FAIL rst_pre_id_reg: got %h expected 8000", d); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL rst_mid_irq_out: got %b expected 0", irq_out); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL rst_mid_irq_id: got %h expected 0", irq_id); end
        checks++; if (readdata !== 16'h0) begin errors++; $display("FAIL rst_mid_readdata: got %h expected 0000", readdata); end
        irq_in = 8'h00;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        rd(3'd2, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_mid_mask: got %h expected 0000", d); end
        rd(3'd1, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_mid_pending: got %h expected 0000", d); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_priority();
        test_set_clear();
        test_masking();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
